// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the 640x480@60 Hz scan controller.
// - VGA line/frame timing in 100 MHz clocks and lines (H_*, V_*)
// - 5x image scaling factors (COL_CLKS, ROW_LINES)
// - Counter and frame-buffer address widths
// - Vertical-phase FSM state encoding
// - in_window(): inclusive range test used for the sync windows
// -----------------------------------------------------------------------------
package vga_pkg;

    // Horizontal timing, in clocks (one pixel is 4 clocks at 100 MHz)
    localparam int H_TOTAL      = 3200;
    localparam int H_ACTIVE     = 2560;
    localparam int H_SYNC_START = 2624;
    localparam int H_SYNC_END   = 3007;

    // Vertical timing, in lines
    localparam int V_TOTAL      = 525;
    localparam int V_ACTIVE     = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 491;

    // 128x96 frame buffer scaled 5x in both directions
    localparam int COL_CLKS     = 20;
    localparam int ROW_LINES    = 5;
    localparam int HPIX_MAX     = 127;
    localparam int VPIX_MAX     = 95;

    // Widths
    localparam int HCNT_W = 12;
    localparam int LINE_W = 10;
    localparam int HSUB_W = 5;
    localparam int CNT_W  = 3;
    localparam int HPIX_W = 7;
    localparam int VPIX_W = 7;
    localparam int ADDR_W = 1 + VPIX_W + HPIX_W;

    typedef enum logic [1:0] {
        ST_V_ACTIVE = 2'd0,
        ST_V_FP     = 2'd1,
        ST_V_SYNC   = 2'd2,
        ST_V_BP     = 2'd3
    } vstate_e;

    function automatic logic in_window(input logic [HCNT_W-1:0] v,
                                       input logic [HCNT_W-1:0] lo,
                                       input logic [HCNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_controller_if.sv
// -----------------------------------------------------------------------------
// vga_scan_controller_if
// Bundles the buffer-swap handshake and the scan outputs of the controller.
// - master: the scan controller (drives scan outputs, receives swap_req)
// - slave : renderer / frame-buffer / RGB stage (drives swap_req)
// Signals: swap_req, swap_ack, H_counter, count, Vpixel, Hpixel, vram_addr,
//          buf_sel, hsync, vsync, video_on, frame_start
// -----------------------------------------------------------------------------
interface vga_scan_controller_if;
    import vga_pkg::*;

    logic                swap_req;
    logic                swap_ack;
    logic [HCNT_W-1:0]   H_counter;
    logic [CNT_W-1:0]    count;
    logic [VPIX_W-1:0]   Vpixel;
    logic [HPIX_W-1:0]   Hpixel;
    logic [ADDR_W-1:0]   vram_addr;
    logic                buf_sel;
    logic                hsync;
    logic                vsync;
    logic                video_on;
    logic                frame_start;

    modport master (
        input  swap_req,
        output swap_ack, H_counter, count, Vpixel, Hpixel, vram_addr,
               buf_sel, hsync, vsync, video_on, frame_start
    );

    modport slave (
        output swap_req,
        input  swap_ack, H_counter, count, Vpixel, Hpixel, vram_addr,
               buf_sel, hsync, vsync, video_on, frame_start
    );

endinterface

// File: rtl/vga_scan_controller_v_pixel_count.sv
// -----------------------------------------------------------------------------
// v_pixel_count
// Image-row tracking: count is the line-repeat index inside one image row,
// vpixel is the image row. Both advance only at the end of a visible line and
// are held at 0 while the display is in vertical blanking.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   line_end_i  : high on the last clock of a line
//   active_i    : vertical FSM is in the visible phase
//   count_o     : line-repeat index, 0..ROW_LINES-1
//   vpixel_o    : image row, 0..95
// -----------------------------------------------------------------------------
module v_pixel_count
    import vga_pkg::*;
#(
    parameter int ROW_LINES = vga_pkg::ROW_LINES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_end_i,
    input  logic              active_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [VPIX_W-1:0] vpixel_o
);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ROW_LINES - 1);
    localparam logic [VPIX_W-1:0] VPIX_LAST = VPIX_W'(VPIX_MAX);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [VPIX_W-1:0] vpix_q, vpix_d;

    always_comb begin
        count_d = count_q;
        vpix_d  = vpix_q;
        if (!active_i) begin
            count_d = '0;
            vpix_d  = '0;
        end else if (line_end_i) begin
            if (count_q == CNT_LAST) begin
                count_d = '0;
                vpix_d  = (vpix_q == VPIX_LAST) ? '0 : vpix_q + 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            vpix_q  <= '0;
        end else begin
            count_q <= count_d;
            vpix_q  <= vpix_d;
        end
    end

    assign count_o  = count_q;
    assign vpixel_o = vpix_q;

endmodule

// File: rtl/vga_scan_controller.sv
// -----------------------------------------------------------------------------
// vga_scan_controller
// Scan sequencer for 640x480@60 Hz VGA from a 100 MHz clock. Runs the
// horizontal clock counter, line counter and vertical-phase FSM, generates
// registered hsync/vsync/video_on, scales the 128x96 frame buffer 5x and
// forms the frame-buffer read address, and performs double-buffer swaps
// requested by the renderer at the end of the visible frame.
// Ports:
//   clk     : 100 MHz system clock
//   reset   : asynchronous active-high reset
//   vga_if  : master side of vga_scan_controller_if (swap handshake in,
//             counters, address, syncs and frame_start out)
// Timing parameters default to the package values; they exist so a scaled
// raster can be run without changing the logic.
// -----------------------------------------------------------------------------
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int H_TOTAL      = vga_pkg::H_TOTAL,
    parameter int H_ACTIVE     = vga_pkg::H_ACTIVE,
    parameter int H_SYNC_START = vga_pkg::H_SYNC_START,
    parameter int H_SYNC_END   = vga_pkg::H_SYNC_END,
    parameter int V_TOTAL      = vga_pkg::V_TOTAL,
    parameter int V_ACTIVE     = vga_pkg::V_ACTIVE,
    parameter int V_SYNC_START = vga_pkg::V_SYNC_START,
    parameter int V_SYNC_END   = vga_pkg::V_SYNC_END,
    parameter int COL_CLKS     = vga_pkg::COL_CLKS,
    parameter int ROW_LINES    = vga_pkg::ROW_LINES
) (
    input  logic                  clk,
    input  logic                  reset,
    vga_scan_controller_if.master vga_if
);

    localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT_END  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_START   = HCNT_W'(H_SYNC_START);
    localparam logic [HCNT_W-1:0] HS_END     = HCNT_W'(H_SYNC_END);
    localparam logic [HCNT_W-1:0] VS_START   = HCNT_W'(V_SYNC_START);
    localparam logic [HCNT_W-1:0] VS_END     = HCNT_W'(V_SYNC_END);
    localparam logic [LINE_W-1:0] L_LAST     = LINE_W'(V_TOTAL - 1);
    localparam logic [LINE_W-1:0] L_ACT_LAST = LINE_W'(V_ACTIVE - 1);
    localparam logic [LINE_W-1:0] L_FP_LAST  = LINE_W'(V_SYNC_START - 1);
    localparam logic [LINE_W-1:0] L_SY_LAST  = LINE_W'(V_SYNC_END);
    localparam logic [HSUB_W-1:0] HSUB_LAST  = HSUB_W'(COL_CLKS - 1);
    localparam logic [HPIX_W-1:0] HPIX_LAST  = HPIX_W'(HPIX_MAX);

    logic [HCNT_W-1:0] h_q, h_d;
    logic [HSUB_W-1:0] hsub_q, hsub_d;
    logic [HPIX_W-1:0] hpix_q, hpix_d;
    logic [LINE_W-1:0] line_q;
    vstate_e           state_q;
    logic              buf_sel_q;
    logic              swap_ack_q;
    logic              hsync_q;
    logic              vsync_q;
    logic              video_on_q;

    logic              line_end;
    logic              v_active;
    logic              h_active;
    logic              frame_end;
    logic [CNT_W-1:0]  count_w;
    logic [VPIX_W-1:0] vpix_w;

    assign line_end  = (h_q == H_LAST);
    assign v_active  = (state_q == ST_V_ACTIVE);
    assign h_active  = (h_q < H_ACT_END);
    // Last clock of the last visible line: the only point where swaps happen
    assign frame_end = line_end && (line_q == L_ACT_LAST);

    // Horizontal counter and image-column counters. hsub/Hpixel are forced
    // to 0 outside the visible area so every visible line starts at column 0.
    always_comb begin
        h_d    = line_end ? '0 : h_q + 1'b1;
        hsub_d = '0;
        hpix_d = '0;
        if (v_active && h_active) begin
            if (hsub_q == HSUB_LAST) begin
                hsub_d = '0;
                hpix_d = (hpix_q == HPIX_LAST) ? '0 : hpix_q + 1'b1;
            end else begin
                hsub_d = hsub_q + 1'b1;
                hpix_d = hpix_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q    <= '0;
            hsub_q <= '0;
            hpix_q <= '0;
        end else begin
            h_q    <= h_d;
            hsub_q <= hsub_d;
            hpix_q <= hpix_d;
        end
    end

    // Vertical FSM with line counter, registered syncs and swap arbitration.
    // Syncs and video_on are one clock behind the counters so they line up
    // with the frame-buffer data read at vram_addr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_V_ACTIVE;
            line_q     <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
            buf_sel_q  <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            hsync_q    <= !in_window(h_q, HS_START, HS_END);
            vsync_q    <= !in_window({{(HCNT_W-LINE_W){1'b0}}, line_q}, VS_START, VS_END);
            video_on_q <= v_active && h_active;
            swap_ack_q <= frame_end && vga_if.swap_req;
            if (frame_end && vga_if.swap_req) begin
                buf_sel_q <= !buf_sel_q;
            end
            if (line_end) begin
                line_q <= (line_q == L_LAST) ? '0 : line_q + 1'b1;
                unique case (state_q)
                    ST_V_ACTIVE: if (line_q == L_ACT_LAST) state_q <= ST_V_FP;
                    ST_V_FP:     if (line_q == L_FP_LAST)  state_q <= ST_V_SYNC;
                    ST_V_SYNC:   if (line_q == L_SY_LAST)  state_q <= ST_V_BP;
                    ST_V_BP:     if (line_q == L_LAST)     state_q <= ST_V_ACTIVE;
                endcase
            end
        end
    end

    v_pixel_count #(
        .ROW_LINES (ROW_LINES)
    ) u_v_pixel_count (
        .clk        (clk),
        .reset      (reset),
        .line_end_i (line_end),
        .active_i   (v_active),
        .count_o    (count_w),
        .vpixel_o   (vpix_w)
    );

    assign vga_if.H_counter   = h_q;
    assign vga_if.Hpixel      = hpix_q;
    assign vga_if.Vpixel      = vpix_w;
    assign vga_if.count       = count_w;
    assign vga_if.buf_sel     = buf_sel_q;
    assign vga_if.vram_addr   = {buf_sel_q, vpix_w, hpix_q};
    assign vga_if.hsync       = hsync_q;
    assign vga_if.vsync       = vsync_q;
    assign vga_if.video_on    = video_on_q;
    assign vga_if.swap_ack    = swap_ack_q;
    // Combinational so it is already high on the first clock after reset
    // is released, while the counters sit at line 0 / clock 0.
    assign vga_if.frame_start = !reset && (h_q == '0) && (line_q == '0);

endmodule

// File: tb/tb_vga_scan_controller.sv
`timescale 1ns/1ps
module tb_vga_scan_controller;

    // Instance 0: full 640x480 timing. Instance 1: scaled raster (1 clk per
    // column, 1 line per row) so whole frames fit in a short run.
    localparam int B_HT = 160, B_HA = 128, B_HSS = 136, B_HSE = 151;
    localparam int B_VT = 105, B_VA = 96,  B_VSS = 100, B_VSE = 101;
    localparam int B_CC = 1,   B_RL = 1;
    localparam int B_FRAME = B_HT * B_VT;

    int HT[2]  = '{3200, B_HT};
    int HA[2]  = '{2560, B_HA};
    int HSS[2] = '{2624, B_HSS};
    int HSE[2] = '{3007, B_HSE};
    int VT[2]  = '{525,  B_VT};
    int VA[2]  = '{480,  B_VA};
    int VSS[2] = '{490,  B_VSS};
    int VSE[2] = '{491,  B_VSE};
    int CC[2]  = '{20,   B_CC};
    int RL[2]  = '{5,    B_RL};

    localparam logic [49:0] RST_VEC = {12'd0, 3'd0, 7'd0, 7'd0, 15'd0, 1'b0,
                                       1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic swap_req = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    vga_scan_controller_if ifa ();
    vga_scan_controller_if ifb ();
    assign ifa.swap_req = swap_req;
    assign ifb.swap_req = swap_req;

    vga_scan_controller u_dut_a (
        .clk    (clk),
        .reset  (reset),
        .vga_if (ifa.master)
    );

    vga_scan_controller #(
        .H_TOTAL (B_HT), .H_ACTIVE (B_HA), .H_SYNC_START (B_HSS), .H_SYNC_END (B_HSE),
        .V_TOTAL (B_VT), .V_ACTIVE (B_VA), .V_SYNC_START (B_VSS), .V_SYNC_END (B_VSE),
        .COL_CLKS (B_CC), .ROW_LINES (B_RL)
    ) u_dut_b (
        .clk    (clk),
        .reset  (reset),
        .vga_if (ifb.master)
    );

    // Reference model: position is derived from the number of clocks since
    // reset; registered outputs are the value of the rule one clock earlier.
    int   cyc = 0;
    logic exp_buf[2] = '{1'b0, 1'b0};
    logic exp_ack[2] = '{1'b0, 1'b0};
    logic exp_hs[2]  = '{1'b1, 1'b1};
    logic exp_vs[2]  = '{1'b1, 1'b1};
    logic exp_von[2] = '{1'b0, 1'b0};

    function automatic int hpos(int i, int c);
        return c % HT[i];
    endfunction

    function automatic int lpos(int i, int c);
        return (c / HT[i]) % VT[i];
    endfunction

    function automatic logic is_frame_end(int i, int c);
        return (hpos(i, c) == HT[i] - 1) && (lpos(i, c) == VA[i] - 1);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc <= 0;
            for (int i = 0; i < 2; i++) begin
                exp_buf[i] <= 1'b0;
                exp_ack[i] <= 1'b0;
                exp_hs[i]  <= 1'b1;
                exp_vs[i]  <= 1'b1;
                exp_von[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_hs[i]  <= !(hpos(i, cyc) >= HSS[i] && hpos(i, cyc) <= HSE[i]);
                exp_vs[i]  <= !(lpos(i, cyc) >= VSS[i] && lpos(i, cyc) <= VSE[i]);
                exp_von[i] <= (hpos(i, cyc) < HA[i]) && (lpos(i, cyc) < VA[i]);
                exp_ack[i] <= is_frame_end(i, cyc) && swap_req;
                if (is_frame_end(i, cyc) && swap_req) exp_buf[i] <= !exp_buf[i];
            end
            cyc <= cyc + 1;
        end
    end

    function automatic logic [49:0] model_vec(int i, int c, logic rst);
        int h, ln, hp, vp, cnt;
        logic act, fs;
        h   = hpos(i, c);
        ln  = lpos(i, c);
        act = (ln < VA[i]);
        hp  = (act && h < HA[i]) ? h / CC[i] : 0;
        vp  = act ? ln / RL[i] : 0;
        cnt = act ? ln % RL[i] : 0;
        fs  = !rst && (h == 0) && (ln == 0);
        return {12'(h), 3'(cnt), 7'(vp), 7'(hp), exp_buf[i], 7'(vp), 7'(hp),
                exp_buf[i], exp_hs[i], exp_vs[i], exp_von[i], exp_ack[i], fs};
    endfunction

    function automatic logic [49:0] dut_vec(int i);
        if (i == 0)
            return {ifa.H_counter, ifa.count, ifa.Vpixel, ifa.Hpixel, ifa.vram_addr,
                    ifa.buf_sel, ifa.hsync, ifa.vsync, ifa.video_on, ifa.swap_ack,
                    ifa.frame_start};
        return {ifb.H_counter, ifb.count, ifb.Vpixel, ifb.Hpixel, ifb.vram_addr,
                ifb.buf_sel, ifb.hsync, ifb.vsync, ifb.video_on, ifb.swap_ack,
                ifb.frame_start};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t cyc=%0d)", name, act, req, $time, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Per-cycle comparison of every output of both instances
    always @(negedge clk) begin
        check("scan_a", 64'(dut_vec(0)), 64'(model_vec(0, cyc, reset)));
        check("scan_b", 64'(dut_vec(1)), 64'(model_vec(1, cyc, reset)));
    end

    // Hand-computed pins on the full-timing instance
    initial begin : pins_a
        int lows;
        wait_cyc(2559);
        check("a_hpix_2559", 64'(ifa.Hpixel), 64'd127);
        wait_cyc(2560);
        check("a_hpix_2560", 64'(ifa.Hpixel), 64'd0);
        check("a_von_2560", 64'(ifa.video_on), 64'd1);
        wait_cyc(2561);
        check("a_von_2561", 64'(ifa.video_on), 64'd0);
        wait_cyc(2624);
        check("a_hs_2624", 64'(ifa.hsync), 64'd1);
        wait_cyc(2625);
        check("a_hs_2625", 64'(ifa.hsync), 64'd0);
        wait_cyc(3008);
        check("a_hs_3008", 64'(ifa.hsync), 64'd0);
        wait_cyc(3009);
        check("a_hs_3009", 64'(ifa.hsync), 64'd1);
        wait_cyc(3199);
        check("a_h_3199", 64'(ifa.H_counter), 64'd3199);
        wait_cyc(3200);
        check("a_h_wrap", 64'(ifa.H_counter), 64'd0);
        check("a_fs_line1", 64'(ifa.frame_start), 64'd0);
        lows = 0;
        for (int c = 3201; c <= 6400; c++) begin
            wait_cyc(c);
            if (ifa.hsync === 1'b0) lows++;
        end
        check("a_hsync_low_clks", 64'(lows), 64'd384);
        wait_cyc(7 * 3200 + 45);
        check("a_vpix_l7", 64'(ifa.Vpixel), 64'd1);
        check("a_hpix_h45", 64'(ifa.Hpixel), 64'd2);
        check("a_count_l7", 64'(ifa.count), 64'd2);
        check("a_vram_addr", 64'(ifa.vram_addr), 64'd130);
    end

    // Hand-computed vertical pins on the scaled instance, first frame
    initial begin : pins_b
        int lows;
        lows = 0;
        for (int c = 1; c <= B_FRAME; c++) begin
            wait_cyc(c);
            if (ifb.vsync === 1'b0) lows++;
            if (c == 95 * B_HT) check("b_vpix_95", 64'(ifb.Vpixel), 64'd95);
            if (c == 96 * B_HT) check("b_vpix_blank", 64'(ifb.Vpixel), 64'd0);
            if (c == 100 * B_HT) check("b_vs_l99", 64'(ifb.vsync), 64'd1);
            if (c == 100 * B_HT + 1) check("b_vs_l100", 64'(ifb.vsync), 64'd0);
        end
        check("b_vsync_low_clks", 64'(lows), 64'(2 * B_HT));
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int acks;
        @(negedge clk);
        check("rst_a", 64'(dut_vec(0)), 64'(RST_VEC));
        check("rst_b", 64'(dut_vec(1)), 64'(RST_VEC));
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("a_fs_release", 64'(ifa.frame_start), 64'd1);
        check("b_fs_release", 64'(ifb.frame_start), 64'd1);

        // Swap requested on line 20 of the scaled frame: ack only at frame end
        wait_cyc(20 * B_HT);
        #1 swap_req = 1'b1;
        while (ifb.swap_ack !== 1'b1 && cyc < B_FRAME + 200) @(negedge clk);
        check("b_ack_cycle", 64'(cyc), 64'(B_VA * B_HT));
        check("b_buf_after_swap", 64'(ifb.buf_sel), 64'd1);
        check("b_addr_msb", 64'(ifb.vram_addr[14]), 64'd1);
        #1 swap_req = 1'b0;

        // Request held across two frame ends: two acks, buffer toggles twice
        wait_cyc(B_FRAME + 1000);
        #1 swap_req = 1'b1;
        acks = 0;
        while (cyc < 3 * B_FRAME + 500) begin
            @(negedge clk);
            if (ifb.swap_ack === 1'b1) acks++;
        end
        check("b_two_acks", 64'(acks), 64'd2);
        check("b_buf_two_swaps", 64'(ifb.buf_sel), 64'd1);
        #1 swap_req = 1'b0;

        // Asynchronous reset in the middle of a visible line
        wait_cyc(3 * B_FRAME + 60 * B_HT + 70);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_a", 64'(dut_vec(0)), 64'(RST_VEC));
        check("rst_mid_b", 64'(dut_vec(1)), 64'(RST_VEC));
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("b_h_restart", 64'(ifb.H_counter), 64'd0);
        check("b_fs_restart", 64'(ifb.frame_start), 64'd1);
        check("b_buf_restart", 64'(ifb.buf_sel), 64'd0);
        wait_cyc(2 * B_HT + 5);
        check("b_h_after_restart", 64'(ifb.H_counter), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
